// File: rtl/multicycle_control_fsm_pkg.sv
// Shared types and encodings for the multicycle control sequencer: states,
// RV32I opcodes, instruction classes and the datapath select encodings.
package cu_pkg;

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB,
    S_TRAP
  } cu_state_t;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  typedef enum logic [3:0] {
    CLS_NOP,
    CLS_R,
    CLS_I,
    CLS_LOAD,
    CLS_STORE,
    CLS_BRANCH,
    CLS_JAL,
    CLS_JALR,
    CLS_LUI
  } instr_class_t;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_RTYPE = 2'b10;
  localparam logic [1:0] ALU_ITYPE = 2'b11;

  localparam logic [1:0] WB_ALU = 2'b00;
  localparam logic [1:0] WB_PC4 = 2'b01;
  localparam logic [1:0] WB_MEM = 2'b10;

  localparam logic [1:0] PC_SRC_PC4 = 2'b00;
  localparam logic [1:0] PC_SRC_IMM = 2'b01;
  localparam logic [1:0] PC_SRC_ALU = 2'b10;

  localparam logic [1:0] TRAP_NONE    = 2'b00;
  localparam logic [1:0] TRAP_ILLEGAL = 2'b01;
  localparam logic [1:0] TRAP_IMEM    = 2'b10;
  localparam logic [1:0] TRAP_DMEM    = 2'b11;

  typedef struct packed {
    logic [1:0] intent;
    logic       src_imm;
  } alu_ctrl_t;

  // ALU operation and operand-B select used while a class is in EXEC.
  function automatic alu_ctrl_t alu_ctrl(input instr_class_t cls);
    alu_ctrl_t c;
    c = '{intent: ALU_ADD, src_imm: 1'b0};
    case (cls)
      CLS_R:      c = '{intent: ALU_RTYPE, src_imm: 1'b0};
      CLS_I:      c = '{intent: ALU_ITYPE, src_imm: 1'b1};
      CLS_LOAD,
      CLS_STORE,
      CLS_JALR,
      CLS_LUI:    c = '{intent: ALU_ADD,   src_imm: 1'b1};
      CLS_BRANCH: c = '{intent: ALU_SUB,   src_imm: 1'b0};
      default:    c = '{intent: ALU_ADD,   src_imm: 1'b0};
    endcase
    return c;
  endfunction

endpackage

// File: rtl/multicycle_control_fsm_opcode_classifier.sv
// Combinational RV32I opcode decoder: maps a 7-bit opcode to an instruction
// class and flags opcodes outside the supported set.
module opcode_classifier
  import cu_pkg::*;
(
  input  logic [6:0]   opcode_i,
  output instr_class_t cls_o,
  output logic         illegal_o
);

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    cls_o     = CLS_NOP;
    illegal_o = 1'b0;
    case (opcode_i)
      OP_R:      cls_o = CLS_R;
      OP_I:      cls_o = CLS_I;
      OP_LOAD:   cls_o = CLS_LOAD;
      OP_STORE:  cls_o = CLS_STORE;
      OP_BRANCH: cls_o = CLS_BRANCH;
      OP_JAL:    cls_o = CLS_JAL;
      OP_JALR:   cls_o = CLS_JALR;
      OP_LUI:    cls_o = CLS_LUI;
      default:   illegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/multicycle_control_fsm.sv
// Multicycle RV32I control sequencer (FETCH/DECODE/EXEC/MEM/WB/TRAP).
// Define CU_ILLEGAL_TRAP_EN to trap on unlisted opcodes; otherwise they run as NOPs.
module multicycle_control_fsm
  import cu_pkg::*;
#(
  parameter int unsigned WAIT_LIMIT = 16
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [6:0] opcode_i,
  input  logic       branch_taken_i,
  input  logic       imem_ready_i,
  input  logic       dmem_ready_i,
  output logic       imem_req,
  output logic       ir_write_en,
  output logic       dmem_req,
  output logic       mem_read_en,
  output logic       mem_write_en,
  output logic       reg_write_en,
  output logic [1:0] rd_src_optn,
  output logic [1:0] alu_intent,
  output logic       alu_src_optn,
  output logic       pc_write_en,
  output logic [1:0] pc_src_optn,
  output logic       trap,
  output logic [1:0] trap_cause
);

  localparam int unsigned CNT_W = (WAIT_LIMIT > 0) ? $clog2(WAIT_LIMIT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(WAIT_LIMIT);

  cu_state_t    state_q;
  instr_class_t cls_q;
  logic [CNT_W-1:0] cnt_q;
  logic [1:0]   cause_q;

  instr_class_t cls_d;
  logic         illegal_d;
  logic         expired;
  alu_ctrl_t    alu_c;

  opcode_classifier u_classifier (
    .opcode_i  (opcode_i),
    .cls_o     (cls_d),
    .illegal_o (illegal_d)
  );

  assign expired = (WAIT_LIMIT != 0) && (cnt_q == CNT_LIMIT);
  assign alu_c   = alu_ctrl(cls_q);

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // samples the pre-edge values of the others.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_FETCH;
      cls_q   <= CLS_NOP;
      cnt_q   <= '0;
      cause_q <= TRAP_NONE;
    end else begin
      case (state_q)
        S_FETCH: begin
          if (imem_ready_i) begin
            state_q <= S_DECODE;
            cnt_q   <= '0;
          end else if (expired) begin
            state_q <= S_TRAP;
            cause_q <= TRAP_IMEM;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        S_DECODE: begin
`ifdef CU_ILLEGAL_TRAP_EN
          cls_q <= cls_d;
          if (illegal_d) begin
            state_q <= S_TRAP;
            cause_q <= TRAP_ILLEGAL;
          end else begin
            state_q <= S_EXEC;
          end
`else
          cls_q   <= illegal_d ? CLS_NOP : cls_d;
          state_q <= S_EXEC;
`endif
        end
        S_EXEC: begin
          cnt_q <= '0;
          if (cls_q == CLS_BRANCH) begin
            state_q <= S_FETCH;
          end else if (cls_q == CLS_LOAD || cls_q == CLS_STORE) begin
            state_q <= S_MEM;
          end else begin
            state_q <= S_WB;
          end
        end
        S_MEM: begin
          if (dmem_ready_i) begin
            state_q <= (cls_q == CLS_LOAD) ? S_WB : S_FETCH;
            cnt_q   <= '0;
          end else if (expired) begin
            state_q <= S_TRAP;
            cause_q <= TRAP_DMEM;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        S_WB: begin
          state_q <= S_FETCH;
          cnt_q   <= '0;
        end
        S_TRAP:  state_q <= S_TRAP;
        default: state_q <= S_FETCH;
      endcase
    end
  end

  // Outputs are forced low in the reset cycle so an abandoned instruction
  // cannot commit a register, PC or memory side effect.
  always_comb begin
    imem_req     = 1'b0;
    ir_write_en  = 1'b0;
    dmem_req     = 1'b0;
    mem_read_en  = 1'b0;
    mem_write_en = 1'b0;
    reg_write_en = 1'b0;
    rd_src_optn  = WB_ALU;
    alu_intent   = ALU_ADD;
    alu_src_optn = 1'b0;
    pc_write_en  = 1'b0;
    pc_src_optn  = PC_SRC_PC4;
    trap         = 1'b0;
    trap_cause   = TRAP_NONE;
    if (!rst_i) begin
      case (state_q)
        S_FETCH: begin
          imem_req    = 1'b1;
          ir_write_en = imem_ready_i;
        end
        S_EXEC: begin
          alu_intent   = alu_c.intent;
          alu_src_optn = alu_c.src_imm;
          if (cls_q == CLS_BRANCH) begin
            pc_write_en = 1'b1;
            pc_src_optn = branch_taken_i ? PC_SRC_IMM : PC_SRC_PC4;
          end
        end
        S_MEM: begin
          dmem_req     = 1'b1;
          mem_read_en  = (cls_q == CLS_LOAD);
          mem_write_en = (cls_q == CLS_STORE);
          pc_write_en  = (cls_q == CLS_STORE) && dmem_ready_i;
        end
        S_WB: begin
          reg_write_en = (cls_q != CLS_NOP);
          pc_write_en  = 1'b1;
          case (cls_q)
            CLS_LOAD: rd_src_optn = WB_MEM;
            CLS_JAL,
            CLS_JALR: rd_src_optn = WB_PC4;
            default:  rd_src_optn = WB_ALU;
          endcase
          case (cls_q)
            CLS_JAL:  pc_src_optn = PC_SRC_IMM;
            CLS_JALR: pc_src_optn = PC_SRC_ALU;
            default:  pc_src_optn = PC_SRC_PC4;
          endcase
        end
        S_TRAP: begin
          trap       = 1'b1;
          trap_cause = cause_q;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Scoreboard bench for multicycle_control_fsm: directed per-cycle stimulus pushes
// hand-written expected strobes; a negedge monitor pops and compares them.
module tb_multicycle_control_fsm;

  localparam logic [6:0] R    = 7'b0110011;
  localparam logic [6:0] IMM  = 7'b0010011;
  localparam logic [6:0] LD   = 7'b0000011;
  localparam logic [6:0] ST   = 7'b0100011;
  localparam logic [6:0] BR   = 7'b1100011;
  localparam logic [6:0] JAL  = 7'b1101111;
  localparam logic [6:0] JALR = 7'b1100111;
  localparam logic [6:0] LUI  = 7'b0110111;
  localparam logic [6:0] BAD  = 7'b1111111;

  typedef struct packed {
    logic       imem_req;
    logic       ir_we;
    logic       dmem_req;
    logic       rd_en;
    logic       wr_en;
    logic       reg_we;
    logic [1:0] rd_src;
    logic [1:0] alu;
    logic       alu_src;
    logic       pc_we;
    logic [1:0] pc_src;
    logic       trap;
    logic [1:0] cause;
  } out_t;

  typedef struct {
    out_t  exp;
    string name;
  } item_t;

  logic clk_i = 1'b0;
  logic rst_i = 1'b1;
  logic [6:0] opcode_i = 7'd0;
  logic branch_taken_i = 1'b0;
  logic imem_ready_i = 1'b0;
  logic dmem_ready_i = 1'b0;
  logic imem_req, ir_write_en, dmem_req, mem_read_en, mem_write_en, reg_write_en;
  logic alu_src_optn, pc_write_en, trap;
  logic [1:0] rd_src_optn, alu_intent, pc_src_optn, trap_cause;

  item_t sb_q[$];
  item_t mon_item;
  out_t  act;
  int    checks = 0;
  int    passed = 0;

  always #5 clk_i = ~clk_i;

  multicycle_control_fsm #(.WAIT_LIMIT(4)) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .opcode_i       (opcode_i),
    .branch_taken_i (branch_taken_i),
    .imem_ready_i   (imem_ready_i),
    .dmem_ready_i   (dmem_ready_i),
    .imem_req       (imem_req),
    .ir_write_en    (ir_write_en),
    .dmem_req       (dmem_req),
    .mem_read_en    (mem_read_en),
    .mem_write_en   (mem_write_en),
    .reg_write_en   (reg_write_en),
    .rd_src_optn    (rd_src_optn),
    .alu_intent     (alu_intent),
    .alu_src_optn   (alu_src_optn),
    .pc_write_en    (pc_write_en),
    .pc_src_optn    (pc_src_optn),
    .trap           (trap),
    .trap_cause     (trap_cause)
  );

  assign act = {imem_req, ir_write_en, dmem_req, mem_read_en, mem_write_en, reg_write_en,
                rd_src_optn, alu_intent, alu_src_optn, pc_write_en, pc_src_optn,
                trap, trap_cause};

  function automatic out_t e_idle();
    return '0;
  endfunction

  function automatic out_t e_fetch(input logic ir);
    out_t e = '0;
    e.imem_req = 1'b1;
    e.ir_we    = ir;
    return e;
  endfunction

  function automatic out_t e_exec(input logic [1:0] alu, input logic src,
                                  input logic pcw, input logic [1:0] pcs);
    out_t e = '0;
    e.alu     = alu;
    e.alu_src = src;
    e.pc_we   = pcw;
    e.pc_src  = pcs;
    return e;
  endfunction

  function automatic out_t e_mem(input logic rd, input logic wr, input logic pcw);
    out_t e = '0;
    e.dmem_req = 1'b1;
    e.rd_en    = rd;
    e.wr_en    = wr;
    e.pc_we    = pcw;
    return e;
  endfunction

  function automatic out_t e_wb(input logic regw, input logic [1:0] rds, input logic [1:0] pcs);
    out_t e = '0;
    e.reg_we = regw;
    e.rd_src = rds;
    e.pc_we  = 1'b1;
    e.pc_src = pcs;
    return e;
  endfunction

  function automatic out_t e_trap(input logic [1:0] c);
    out_t e = '0;
    e.trap  = 1'b1;
    e.cause = c;
    return e;
  endfunction

  // One clock cycle: drive inputs just after the edge and queue that cycle's expectation.
  task automatic step(input logic rst, input logic ir, input logic dr, input logic bt,
                      input logic [6:0] op, input out_t e, input string name);
    item_t it;
    @(posedge clk_i);
    #1;
    rst_i          = rst;
    imem_ready_i   = ir;
    dmem_ready_i   = dr;
    branch_taken_i = bt;
    opcode_i       = op;
    it.exp  = e;
    it.name = name;
    sb_q.push_back(it);
  endtask

  // Zero-wait FETCH followed by DECODE of the given opcode.
  task automatic fd(input logic [6:0] op, input string name);
    step(1'b0, 1'b1, 1'b0, 1'b0, op, e_fetch(1'b1), {name, "_fetch"});
    step(1'b0, 1'b0, 1'b0, 1'b0, op, e_idle(), {name, "_decode"});
  endtask

  initial begin
    forever begin
      @(negedge clk_i);
      if (sb_q.size() > 0) begin
        mon_item = sb_q.pop_front();
        checks++;
        if (act === mon_item.exp) passed++;
        else $display("FAIL %s: got %h expected %h", mon_item.name, act, mon_item.exp);
      end
    end
  end

  initial begin
    step(1'b1, 1'b1, 1'b1, 1'b1, R, e_idle(), "reset0");
    step(1'b1, 1'b0, 1'b0, 1'b0, R, e_idle(), "reset1");

    fd(R, "r");
    step(1'b0, 1'b0, 1'b0, 1'b0, R, e_exec(2'b10, 1'b0, 1'b0, 2'b00), "r_exec");
    step(1'b0, 1'b0, 1'b0, 1'b0, R, e_wb(1'b1, 2'b00, 2'b00), "r_wb");

    fd(LD, "ld");
    step(1'b0, 1'b0, 1'b0, 1'b0, LD, e_exec(2'b00, 1'b1, 1'b0, 2'b00), "ld_exec");
    for (int i = 0; i < 3; i++)
      step(1'b0, 1'b0, 1'b0, 1'b0, LD, e_mem(1'b1, 1'b0, 1'b0), "ld_mem_wait");
    step(1'b0, 1'b0, 1'b1, 1'b0, LD, e_mem(1'b1, 1'b0, 1'b0), "ld_mem_ready");
    step(1'b0, 1'b0, 1'b0, 1'b0, LD, e_wb(1'b1, 2'b10, 2'b00), "ld_wb");

    fd(BR, "br_t");
    step(1'b0, 1'b0, 1'b0, 1'b1, BR, e_exec(2'b01, 1'b0, 1'b1, 2'b01), "br_taken_exec");
    fd(BR, "br_n");
    step(1'b0, 1'b0, 1'b0, 1'b0, BR, e_exec(2'b01, 1'b0, 1'b1, 2'b00), "br_not_taken_exec");

    fd(JALR, "jalr");
    step(1'b0, 1'b0, 1'b0, 1'b0, JALR, e_exec(2'b00, 1'b1, 1'b0, 2'b00), "jalr_exec");
    step(1'b0, 1'b0, 1'b0, 1'b0, JALR, e_wb(1'b1, 2'b01, 2'b10), "jalr_wb");

    step(1'b0, 1'b0, 1'b0, 1'b0, ST, e_fetch(1'b0), "st_fetch_wait");
    fd(ST, "st");
    step(1'b0, 1'b0, 1'b0, 1'b1, ST, e_exec(2'b00, 1'b1, 1'b0, 2'b00), "st_exec");
    step(1'b0, 1'b0, 1'b0, 1'b0, ST, e_mem(1'b0, 1'b1, 1'b0), "st_mem_wait");
    step(1'b0, 1'b0, 1'b1, 1'b0, ST, e_mem(1'b0, 1'b1, 1'b1), "st_mem_ready");

    fd(JAL, "jal");
    step(1'b0, 1'b0, 1'b0, 1'b0, JAL, e_exec(2'b00, 1'b0, 1'b0, 2'b00), "jal_exec");
    step(1'b0, 1'b0, 1'b0, 1'b0, JAL, e_wb(1'b1, 2'b01, 2'b01), "jal_wb");
    fd(LUI, "lui");
    step(1'b0, 1'b0, 1'b0, 1'b0, LUI, e_exec(2'b00, 1'b1, 1'b0, 2'b00), "lui_exec");
    step(1'b0, 1'b0, 1'b0, 1'b0, LUI, e_wb(1'b1, 2'b00, 2'b00), "lui_wb");
    fd(IMM, "itype");
    step(1'b0, 1'b0, 1'b0, 1'b0, IMM, e_exec(2'b11, 1'b1, 1'b0, 2'b00), "itype_exec");
    step(1'b0, 1'b0, 1'b0, 1'b0, IMM, e_wb(1'b1, 2'b00, 2'b00), "itype_wb");

    fd(LD, "rstmem");
    step(1'b0, 1'b0, 1'b0, 1'b0, LD, e_exec(2'b00, 1'b1, 1'b0, 2'b00), "rstmem_exec");
    step(1'b0, 1'b0, 1'b0, 1'b0, LD, e_mem(1'b1, 1'b0, 1'b0), "rstmem_mem");
    step(1'b1, 1'b0, 1'b1, 1'b0, LD, e_idle(), "rst_in_mem");
    step(1'b0, 1'b0, 1'b0, 1'b0, LD, e_fetch(1'b0), "fetch_after_rst");

    fd(BAD, "bad");
`ifdef CU_ILLEGAL_TRAP_EN
    step(1'b0, 1'b1, 1'b1, 1'b0, BAD, e_trap(2'b01), "illegal_trap0");
    step(1'b0, 1'b1, 1'b1, 1'b0, BAD, e_trap(2'b01), "illegal_trap1");
`else
    step(1'b0, 1'b0, 1'b0, 1'b0, BAD, e_exec(2'b00, 1'b0, 1'b0, 2'b00), "nop_exec");
    step(1'b0, 1'b0, 1'b0, 1'b0, BAD, e_wb(1'b0, 2'b00, 2'b00), "nop_wb");
    step(1'b0, 1'b0, 1'b0, 1'b0, BAD, e_fetch(1'b0), "nop_next_fetch");
`endif
    step(1'b1, 1'b0, 1'b0, 1'b0, R, e_idle(), "rst_a");

    for (int i = 0; i < 4; i++)
      step(1'b0, 1'b0, 1'b0, 1'b0, R, e_fetch(1'b0), "limit_wait");
    step(1'b0, 1'b1, 1'b0, 1'b0, R, e_fetch(1'b1), "ready_at_limit");
    step(1'b0, 1'b0, 1'b0, 1'b0, R, e_idle(), "limit_decode");
    step(1'b0, 1'b0, 1'b0, 1'b0, R, e_exec(2'b10, 1'b0, 1'b0, 2'b00), "limit_exec");
    step(1'b0, 1'b0, 1'b0, 1'b0, R, e_wb(1'b1, 2'b00, 2'b00), "limit_wb");

    for (int i = 0; i < 5; i++)
      step(1'b0, 1'b0, 1'b0, 1'b0, R, e_fetch(1'b0), "imem_stuck");
    step(1'b0, 1'b1, 1'b0, 1'b0, R, e_trap(2'b10), "imem_timeout0");
    step(1'b0, 1'b1, 1'b1, 1'b0, R, e_trap(2'b10), "imem_timeout1");
    step(1'b1, 1'b0, 1'b0, 1'b0, R, e_idle(), "rst_clears_trap");

    fd(LD, "dto");
    step(1'b0, 1'b0, 1'b0, 1'b0, LD, e_exec(2'b00, 1'b1, 1'b0, 2'b00), "dto_exec");
    for (int i = 0; i < 5; i++)
      step(1'b0, 1'b0, 1'b0, 1'b0, LD, e_mem(1'b1, 1'b0, 1'b0), "dmem_stuck");
    step(1'b0, 1'b0, 1'b1, 1'b0, LD, e_trap(2'b11), "dmem_timeout0");
    step(1'b0, 1'b0, 1'b1, 1'b0, LD, e_trap(2'b11), "dmem_timeout1");
    step(1'b1, 1'b0, 1'b0, 1'b0, LD, e_idle(), "rst_b");
    step(1'b0, 1'b1, 1'b0, 1'b0, R, e_fetch(1'b1), "final_fetch");

    @(negedge clk_i);
    #1;
    checks++;
    if (sb_q.size() == 0) passed++;
    else $display("FAIL scoreboard_drain: got %0d pending expected 0", sb_q.size());

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/multicycle_control_fsm.md
# multicycle_control_fsm

Multicycle control sequencer for the RV32I core. It steps each instruction through FETCH, DECODE, EXEC, MEM and WB states, and issues state-qualified control strobes to the datapath. It waits on ready handshakes from instruction and data memory, so variable-latency memories work. Memory timeouts and illegal opcodes divert it to a sticky TRAP state.

## Interface
- `WAIT_LIMIT`, 16: maximum wait cycles per memory request before a timeout trap; 0 disables the timeout.
- `clk_i` in 1: core clock; all state changes on rising edge.
- `rst_i` in 1: synchronous, active-high reset.
- `opcode_i` in 7: opcode from the instruction register; valid from DECODE onward.
- `branch_taken_i` in 1: comparator result; sampled in EXEC of a branch.
- `imem_ready_i` in 1: instruction memory has data this cycle.
- `dmem_ready_i` in 1: data memory has completed the access this cycle.
- `imem_req` out 1: instruction fetch request.
- `ir_write_en` out 1: latch the fetched word into the instruction register.
- `dmem_req` out 1: data memory request.
- `mem_read_en` out 1: data request is a load.
- `mem_write_en` out 1: data request is a store.
- `reg_write_en` out 1: register file write.
- `rd_src_optn` out 2: write-back source; 00=ALU, 01=PC+4, 10=Mem.
- `alu_intent` out 2: ALU operation; 00=Add, 01=Sub, 10=R-Type, 11=I-Type.
- `alu_src_optn` out 1: ALU operand B; 0=RegB, 1=Immediate.
- `pc_write_en` out 1: update the PC.
- `pc_src_optn` out 2: PC source; 00=PC+4, 01=PC+imm, 10=ALU result with LSB cleared.
- `trap` out 1: core halted.
- `trap_cause` out 2: 00=none, 01=illegal opcode, 10=imem timeout, 11=dmem timeout.

## Operation
- **Output rule.** Outputs are combinational from the registered state plus the class latched in DECODE. When no state drives an output it is 0.
- **FETCH**
  - Hold `imem_req` high until `imem_ready_i`.
  - In the ready cycle, pulse `ir_write_en` for 1 cycle and go to DECODE.
- **DECODE**
  - Classify `opcode_i` and register the class.
  - Next state is EXEC, or TRAP if the opcode is illegal (macro-dependent).
- **EXEC**
  - Drive `alu_intent` and `alu_src_optn` with the standard per-class encodings (R, I, LOAD, STORE, BRANCH=Sub, JALR=Add+Imm, LUI=Add+Imm).
  - BRANCH: `pc_write_en`=1 and go to FETCH. `pc_src_optn`=01 if `branch_taken_i`, else 00.
  - LOAD and STORE go to MEM. All other classes go to WB.
- **MEM**
  - Hold `dmem_req` high with `mem_read_en` or `mem_write_en` until `dmem_ready_i`.
  - On ready, LOAD goes to WB.
  - On ready, STORE asserts `pc_write_en` with `pc_src_optn`=00 and goes to FETCH.
- **WB**
  - `reg_write_en`=1 and `pc_write_en`=1, both for one cycle; then go to FETCH.
  - `rd_src_optn`: LOAD=10, JAL/JALR=01, others=00.
  - `pc_src_optn`: JAL=01, JALR=10, others=00.
  - The PC changes only in an instruction's final cycle, so the PC+4 link value still refers to the instruction's own PC.
- **TRAP**
  - Sticky: `trap`=1 and `trap_cause` held; all strobes are 0.
  - Exits only through `rst_i`.
- **Wait counter**
  - Width `$clog2(WAIT_LIMIT+1)`. Clears on entry to FETCH or MEM; increments each cycle the ready input is low.
  - When it reaches `WAIT_LIMIT` with ready still low: go to TRAP with cause 10 (FETCH) or 11 (MEM).
  - Ready has priority over expiry in the same cycle.

## Timing
- **Reset.** While `rst_i`=1, every output is 0, state=FETCH, counter=0, `trap_cause`=00. The first `imem_req` appears in the cycle after `rst_i` falls.
- **Reset mid-instruction.** Abandons the instruction. No register, PC or memory strobe is asserted in the reset cycle; the outstanding request is dropped.
- **Cycle counts** (zero-wait memories):
  - BRANCH: 3
  - R, I, LUI, JAL, JALR, STORE: 4
  - LOAD: 5
  - Each wait cycle adds 1.
- Ready inputs are sampled only while the matching request is high; they are ignored otherwise.

## Configuration
- `CU_ILLEGAL_TRAP_EN` defined: any unlisted opcode goes DECODE→TRAP with cause 01.
- `CU_ILLEGAL_TRAP_EN` undefined: an unlisted opcode executes as a NOP. Path is DECODE→EXEC→WB with `reg_write_en`=0 and `pc_write_en`=1, `pc_src_optn`=00 (4 cycles).

## Structure
- Package `cu_pkg` holds:
  - the state enum `cu_state_t`;
  - the opcode localparams and the instruction-class enum;
  - the `ALU_*`, `WB_*`, `PC_SRC_*` and `TRAP_*` constants.
- Sub-module `opcode_classifier`: combinational, opcode→class plus illegal flag. It is instantiated once in DECODE.

## Test plan
- R-type `0110011`, zero-wait memories: strobes FETCH(`ir_write_en`), DECODE, EXEC(`alu_intent`=10), WB(`reg_write_en`, `rd_src_optn`=00, `pc_src_optn`=00). `imem_req` returns in cycle 5.
- LOAD, `dmem_ready_i` delayed 3 cycles: `dmem_req`+`mem_read_en` high for 4 cycles; WB `rd_src_optn`=10; 8 cycles total.
- BRANCH with `branch_taken_i`=1, then 0: EXEC asserts `pc_write_en` with `pc_src_optn`=01, then 00; 3 cycles each; `reg_write_en` never asserted.
- JALR: EXEC `alu_src_optn`=1; WB `reg_write_en`=1, `rd_src_optn`=01, `pc_src_optn`=10.
- `WAIT_LIMIT`=4, `imem_ready_i` stuck low: `trap`=1 and `trap_cause`=10 after 4 wait cycles. Repeat with ready rising exactly at cycle 4: no trap.
- Opcode `1111111` with macro on: `trap_cause`=01. With macro off: 4-cycle NOP, then the next fetch. Also assert `rst_i` during MEM and check all outputs are 0 and the next cycle is FETCH.
